// File: rtl/adc_poll_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_poll_pkg
// Purpose  : Shared types and constants for the adc_poller scan engine:
//            scan FSM state encoding, channel count, the power-on centre
//            value for the channel holding registers and default strobe and
//            conversion timings.
// Revision : 1.0  initial release
// ============================================================================
package adc_poll_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    CONV = 3'd2,
    RD   = 3'd3,
    NEXT = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [7:0] ADC_CENTER        = 8'd127;
  localparam int         NUM_CH            = 4;
  localparam int         DEF_STROBE_CYCLES = 2;
  localparam int         DEF_CONV_CYCLES   = 64;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_poller_if.sv
`default_nettype none
// ============================================================================
// Interface: adc_poller_if
// Purpose  : ADC-style I/O port bus between the poller (master) and the
//            analog-input responder (slave).
// Signals  : adc_a[1:0]    channel address (master -> slave)
//            adc_wr_n      start-conversion strobe, active low
//            adc_rd_n      read strobe, active low
//            adc_data[7:0] conversion result (slave -> master)
// Revision : 1.0  initial release
// ============================================================================
interface adc_poller_if;
  logic [1:0] adc_a;
  logic       adc_wr_n;
  logic       adc_rd_n;
  logic [7:0] adc_data;

  modport master (
    output adc_a,
    output adc_wr_n,
    output adc_rd_n,
    input  adc_data
  );

  modport slave (
    input  adc_a,
    input  adc_wr_n,
    input  adc_rd_n,
    output adc_data
  );
endinterface
`default_nettype wire

// File: rtl/adc_poll_timer.sv
`default_nettype none
// ============================================================================
// Module   : adc_poll_timer
// Purpose  : Loadable down-counter used to time strobe and conversion
//            phases. Loaded with (count - 1) on state entry; o_zero flags
//            the last cycle of the phase. Holds at zero when not loaded.
// Ports    : clk, rst     clock, asynchronous active-high reset
//            i_load       load i_load_val this cycle
//            i_load_val   value to load (phase length - 1)
//            o_zero       counter is zero
// Revision : 1.0  initial release
// ============================================================================
module adc_poll_timer #(
  parameter int WIDTH = 7
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  output logic                  o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/adc_poller.sv
`default_nettype none
// ============================================================================
// Module   : adc_poller
// Purpose  : Once per frame (rising edge of vblank) scans ADC channels 0..3
//            with a write-strobe / conversion-wait / read-strobe sequence
//            and latches each 8-bit result into a holding register.
// Ports    : clk6m, reset  clock, asynchronous active-high reset
//            vblank        frame blanking, rising edge starts a scan
//            adc           ADC bus (master modport of adc_poller_if)
//            ch0..ch3      latched channel values (reset to 127)
//            busy          high whenever the FSM is not idle
//            done          one-cycle pulse at scan completion
//            overrun       sticky: trigger seen while busy (cleared by reset)
// Config   : ADC_POLL_FILTER_EN - when defined each capture stores
//            (old + new + 1) >> 1 instead of the raw sample.
// Revision : 1.0  initial release
// ============================================================================
module adc_poller
  import adc_poll_pkg::*;
#(
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int CONV_CYCLES   = DEF_CONV_CYCLES
) (
  input  wire logic       clk6m,
  input  wire logic       reset,
  input  wire logic       vblank,
  adc_poller_if.master    adc,
  output logic [7:0]      ch0,
  output logic [7:0]      ch1,
  output logic [7:0]      ch2,
  output logic [7:0]      ch3,
  output logic            busy,
  output logic            done,
  output logic            overrun
);

  localparam int              TMAX          = max2(STROBE_CYCLES, CONV_CYCLES);
  localparam int              TW            = $clog2(TMAX) + 1;
  localparam logic [TW-1:0]   C_STROBE_LOAD = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0]   C_CONV_LOAD   = TW'(CONV_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_hist;
  logic        w_rise;
  logic [1:0]  r_ch_idx;
  logic [1:0]  w_ch_idx_next;
  logic        w_load;
  logic [TW-1:0] w_load_val;
  logic        w_zero;
  logic        w_capture;
  logic [7:0]  w_cap_val;
  logic [7:0]  r_ch [NUM_CH];

  logic [1:0]  r_adc_a;
  logic        r_wr_n;
  logic        r_rd_n;
  logic        r_busy;
  logic        r_done;
  logic        r_overrun;

  assign w_rise = vblank & ~r_hist;

  adc_poll_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk6m),
    .rst        (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // Next-state logic; the timer is loaded on the transition into each timed
  // state so that phase length equals the loaded value plus one.
  always_comb begin
    w_next        = r_state;
    w_ch_idx_next = r_ch_idx;
    w_load        = 1'b0;
    w_load_val    = C_STROBE_LOAD;
    w_capture     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_next        = WR;
          w_ch_idx_next = 2'd0;
          w_load        = 1'b1;
        end
      end
      WR: begin
        if (w_zero) begin
          w_next     = CONV;
          w_load     = 1'b1;
          w_load_val = C_CONV_LOAD;
        end
      end
      CONV: begin
        if (w_zero) begin
          w_next = RD;
          w_load = 1'b1;
        end
      end
      RD: begin
        if (w_zero) begin
          w_capture = 1'b1;
          w_next    = NEXT;
        end
      end
      NEXT: begin
        if (r_ch_idx == 2'd3) begin
          w_next = DONE;
        end else begin
          w_ch_idx_next = r_ch_idx + 2'd1;
          w_next        = WR;
          w_load        = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef ADC_POLL_FILTER_EN
  logic [8:0] w_sum;
  always_comb begin
    w_sum     = {1'b0, r_ch[r_ch_idx]} + {1'b0, adc.adc_data} + 9'd1;
    w_cap_val = w_sum[8:1];
  end
`else
  always_comb begin
    w_cap_val = adc.adc_data;
  end
`endif

  always_ff @(posedge clk6m or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_hist  <= 1'b0;
      r_ch_idx <= 2'd0;
    end else begin
      r_state  <= w_next;
      r_hist   <= vblank;
      r_ch_idx <= w_ch_idx_next;
    end
  end

  // Bus and status outputs are registered from the next state so they
  // change exactly on the state transition and never glitch.
  always_ff @(posedge clk6m or posedge reset) begin
    if (reset) begin
      r_adc_a   <= 2'd0;
      r_wr_n    <= 1'b1;
      r_rd_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_adc_a   <= w_ch_idx_next;
      r_wr_n    <= (w_next != WR);
      r_rd_n    <= (w_next != RD);
      r_busy    <= (w_next != IDLE);
      r_done    <= (w_next == DONE);
      // Any trigger outside IDLE (including the DONE cycle) is dropped.
      r_overrun <= r_overrun | (w_rise & (r_state != IDLE));
    end
  end

  always_ff @(posedge clk6m or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_ch[i] <= ADC_CENTER;
      end
    end else if (w_capture) begin
      r_ch[r_ch_idx] <= w_cap_val;
    end
  end

  assign adc.adc_a    = r_adc_a;
  assign adc.adc_wr_n = r_wr_n;
  assign adc.adc_rd_n = r_rd_n;
  assign ch0          = r_ch[0];
  assign ch1          = r_ch[1];
  assign ch2          = r_ch[2];
  assign ch3          = r_ch[3];
  assign busy         = r_busy;
  assign done         = r_done;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adc_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_poller
// Purpose  : Self-checking bench for adc_poller (default parameters).
//            Expected channel values per scan are queued at trigger time and
//            compared by an independent monitor when done pulses; strobe
//            timing is checked continuously on the falling clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_poller;

  typedef struct packed {
    logic [7:0] c3;
    logic [7:0] c2;
    logic [7:0] c1;
    logic [7:0] c0;
    logic       ovr;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       vblank;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic       busy, done, overrun;
  logic [7:0] tbl [4];
  logic [7:0] mdl [4];

  exp_t sb[$];
  int   total;
  int   bad;
  int   cyc;
  int   done_cnt;

  adc_poller_if u_if ();

  adc_poller #(
    .STROBE_CYCLES (2),
    .CONV_CYCLES   (64)
  ) dut (
    .clk6m   (clk),
    .reset   (reset),
    .vblank  (vblank),
    .adc     (u_if),
    .ch0     (ch0),
    .ch1     (ch1),
    .ch2     (ch2),
    .ch3     (ch3),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  // Responder: presents the table entry for the addressed channel while
  // the read strobe is low.
  always_comb begin
    u_if.adc_data = 8'h00;
    if (!u_if.adc_rd_n) u_if.adc_data = tbl[u_if.adc_a];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] cap(input logic [7:0] old_v, input logic [7:0] new_v);
`ifdef ADC_POLL_FILTER_EN
    logic [8:0] s;
    s = {1'b0, old_v} + {1'b0, new_v} + 9'd1;
    return s[8:1];
`else
    return new_v;
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_tbl(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
  endtask

  task automatic push_model(input logic ovr);
    exp_t e;
    for (int i = 0; i < 4; i++) mdl[i] = cap(mdl[i], tbl[i]);
    e.c0 = mdl[0]; e.c1 = mdl[1]; e.c2 = mdl[2]; e.c3 = mdl[3]; e.ovr = ovr;
    sb.push_back(e);
  endtask

  // vblank rises at posedge+1; the scan must start on the very next edge.
  task automatic trigger();
    vblank = 1'b1;
    step(1);
    check("latency_wr_n", u_if.adc_wr_n, 0);
    check("latency_busy", busy, 1);
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ch0"}, ch0, 8'd127);
    check({tag, "_ch1"}, ch1, 8'd127);
    check({tag, "_ch2"}, ch2, 8'd127);
    check({tag, "_ch3"}, ch3, 8'd127);
    check({tag, "_wr_n"}, u_if.adc_wr_n, 1);
    check({tag, "_rd_n"}, u_if.adc_rd_n, 1);
    check({tag, "_a"}, u_if.adc_a, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  // Monitor: scoreboard pop on done, scan length, strobe timing.
  int         m_start;
  bit         m_in_scan;
  bit         m_prev_wr;
  bit         m_prev_rd;
  int         m_wr_w;
  int         m_rd_w;
  int         m_gap;
  bit         m_gap_on;
  bit         m_in_ch;
  logic [1:0] m_a_ref;

  initial begin
    m_in_scan = 0; m_prev_wr = 1; m_prev_rd = 1; m_gap_on = 0; m_in_ch = 0;
    m_wr_w = 0; m_rd_w = 0; m_gap = 0; m_start = 0; m_a_ref = 2'd0;
  end

  always @(negedge clk) begin
    if (reset) begin
      m_in_scan = 0; m_prev_wr = 1; m_prev_rd = 1; m_gap_on = 0; m_in_ch = 0;
      m_wr_w = 0; m_rd_w = 0; m_gap = 0;
    end else begin
      if (!u_if.adc_wr_n && !m_in_scan) begin
        m_in_scan = 1;
        m_start   = cyc;
      end
      if (busy) check("strobe_overlap", int'(!u_if.adc_wr_n && !u_if.adc_rd_n), 0);
      if (!u_if.adc_wr_n) begin
        if (m_prev_wr) begin
          m_wr_w  = 0;
          m_a_ref = u_if.adc_a;
          m_in_ch = 1;
        end
        m_wr_w++;
      end
      if (u_if.adc_wr_n && !m_prev_wr) begin
        check("wr_width", m_wr_w, 2);
        m_gap_on = 1;
        m_gap    = 0;
      end
      if (m_gap_on && u_if.adc_wr_n && u_if.adc_rd_n) m_gap++;
      if (!u_if.adc_rd_n && m_prev_rd) begin
        check("conv_gap", m_gap, 64);
        m_gap_on = 0;
        m_rd_w   = 0;
      end
      if (!u_if.adc_rd_n) m_rd_w++;
      if (u_if.adc_rd_n && !m_prev_rd) begin
        check("rd_width", m_rd_w, 2);
        m_in_ch = 0;
      end
      if (m_in_ch) check("a_stable", u_if.adc_a, m_a_ref);
      m_prev_wr = u_if.adc_wr_n;
      m_prev_rd = u_if.adc_rd_n;

      if (done) begin
        done_cnt++;
        check("scan_len", cyc - m_start + 1, 277);
        m_in_scan = 0;
        check("sb_has_entry", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_ch0", ch0, e.c0);
          check("sb_ch1", ch1, e.c1);
          check("sb_ch2", ch2, e.c2);
          check("sb_ch3", ch3, e.c3);
          check("sb_overrun", overrun, e.ovr);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d0;
    total = 0; bad = 0; cyc = 0; done_cnt = 0;
    reset = 1'b1; vblank = 1'b0;
    set_tbl(8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) mdl[i] = 8'd127;

    // Reset state
    step(3);
    check_reset_vals("rst");
    reset = 1'b0;
    step(2);
    check("post_rst_busy", busy, 0);

    // Basic scan: 10/20/30/40
    set_tbl(8'h10, 8'h20, 8'h30, 8'h40);
    push_model(1'b0);
    trigger();
    step(4);
    vblank = 1'b0;
    drain(1000);
    check("b_busy", busy, 0);
    check("b_overrun", overrun, 0);
`ifndef ADC_POLL_FILTER_EN
    check("b_ch0_raw", ch0, 8'h10);
    check("b_ch3_raw", ch3, 8'h40);
`endif
    step(5);

    // Second rise 100 cycles into a scan: ignored, overrun set
    set_tbl(8'h01, 8'h02, 8'h03, 8'h04);
    push_model(1'b1);
    d0 = done_cnt;
    trigger();
    step(4);
    vblank = 1'b0;
    step(95);
    vblank = 1'b1;
    step(1);
    check("c_overrun_set", overrun, 1);
    check("c_still_busy", busy, 1);
    step(3);
    vblank = 1'b0;
    drain(1000);
    step(300);
    check("c_done_once", done_cnt - d0, 1);
    check("c_overrun_sticky", overrun, 1);
    check("c_idle", busy, 0);

    // Reset during CONV of channel 2
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'd127;
    check("d_overrun_cleared", overrun, 0);
    step(2);
    set_tbl(8'h55, 8'h55, 8'hAA, 8'hAA);
    trigger();
    step(4);
    vblank = 1'b0;
    k = 0;
    while (!(u_if.adc_a == 2'd2 && !u_if.adc_wr_n) && k < 1000) begin
      step(1);
      k++;
    end
    check("d_reach_ch2", int'(k < 1000), 1);
    step(10);
    check("d_ch0_captured", ch0, cap(8'd127, 8'h55));
    check("d_ch1_captured", ch1, cap(8'd127, 8'h55));
    check("d_ch2_untouched", ch2, 8'd127);
    check("d_in_conv_wr_n", u_if.adc_wr_n, 1);
    check("d_in_conv_busy", busy, 1);
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    step(2);
    reset = 1'b0;
    step(2);
    check("d_no_done_after", done_cnt, d0 + 1);

    // Filter / raw capture with responder at 0xFF
    set_tbl(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    begin
      exp_t e;
`ifdef ADC_POLL_FILTER_EN
      e = {8'hBF, 8'hBF, 8'hBF, 8'hBF, 1'b0};
`else
      e = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0};
`endif
      sb.push_back(e);
    end
    trigger();
    step(4);
    vblank = 1'b0;
    drain(1000);
    step(5);
    begin
      exp_t e;
`ifdef ADC_POLL_FILTER_EN
      e = {8'hDF, 8'hDF, 8'hDF, 8'hDF, 1'b0};
`else
      e = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0};
`endif
      sb.push_back(e);
    end
    trigger();
    step(4);
    vblank = 1'b0;
    drain(1000);
    check("e_total_done", done_cnt, d0 + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
